// File: rtl/pong_pkg.sv
// Shared Pong definitions: FSM state encoding and default gameplay constants,
// used by the game controller and the graphics path.
package pong_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SERVE = 3'd1,
        PLAY  = 3'd2,
        MISS  = 3'd3,
        OVER  = 3'd4
    } pong_state_t;

    localparam int BALL_VEL0_DEF    = 5;
    localparam int VEL_STEP_DEF     = 2;
    localparam int VEL_MAX_DEF      = 15;
    localparam int BAR_S0_DEF       = 200;
    localparam int BAR_DEC_DEF      = 50;
    localparam int BAR_MIN_DEF      = 50;
    localparam int HITS_PER_LVL_DEF = 2;
    localparam int LIVES0_DEF       = 3;
    localparam int SERVE_FRAMES_DEF = 60;
    localparam int MISS_FRAMES_DEF  = 90;

    localparam int FRAME_CNT_W = 8;

endpackage

// File: rtl/pong_game_ctrl_if.sv
// Raster position, gameplay events and game status between the Pong
// controller and its surroundings.
interface pong_game_ctrl_if;

    logic        GameOn;
    logic        GameStartdb;
    logic [16:0] HCount;
    logic [16:0] VCount;
    logic        paddle_hit;
    logic        ball_miss;

    logic        frame_tick;
    logic        play_en;
    logic        ball_rst;
    logic [3:0]  ball_vel;
    logic [9:0]  bar_size;
    logic [7:0]  score;
    logic [1:0]  lives;
    logic [3:0]  level;
    logic [2:0]  state;

    modport slave (
        input  GameOn, GameStartdb, HCount, VCount, paddle_hit, ball_miss,
        output frame_tick, play_en, ball_rst, ball_vel, bar_size,
               score, lives, level, state
    );

    modport master (
        output GameOn, GameStartdb, HCount, VCount, paddle_hit, ball_miss,
        input  frame_tick, play_en, ball_rst, ball_vel, bar_size,
               score, lives, level, state
    );

endinterface

// File: rtl/pong_frame_timer.sv
// Frame pulse from the raster origin plus a frame counter whose done flag
// fires on the target-th tick since the last clear.
module pong_frame_timer
    import pong_pkg::*;
(
    input  logic                   CLK_65MHz,
    input  logic                   Clear,
    input  logic [16:0]            HCount,
    input  logic [16:0]            VCount,
    input  logic                   clr,
    input  logic [FRAME_CNT_W-1:0] target,
    output logic                   frame_tick,
    output logic                   done
);

    logic                   frame_tick_reg;
    logic [FRAME_CNT_W-1:0] frame_cnt_reg;

    always_ff @(posedge CLK_65MHz) begin
        if (!Clear) begin
            frame_tick_reg <= 1'b0;
            frame_cnt_reg  <= '0;
        end else begin
            frame_tick_reg <= (HCount == 17'd0) && (VCount == 17'd0);
            // Clear wins over a coincident tick so a new state starts at zero.
            if (clr)
                frame_cnt_reg <= '0;
            else if (frame_tick_reg)
                frame_cnt_reg <= frame_cnt_reg + 1'b1;
        end
    end

    assign frame_tick = frame_tick_reg;
    assign done       = frame_tick_reg && (frame_cnt_reg == target - 1'b1);

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong game controller: serve/play/miss/over sequencing, lives, score and
// level-driven ball speed and paddle size.
module pong_game_ctrl
    import pong_pkg::*;
#(
    parameter int BALL_VEL0    = BALL_VEL0_DEF,
    parameter int VEL_STEP     = VEL_STEP_DEF,
    parameter int VEL_MAX      = VEL_MAX_DEF,
    parameter int BAR_S0       = BAR_S0_DEF,
    parameter int BAR_DEC      = BAR_DEC_DEF,
    parameter int BAR_MIN      = BAR_MIN_DEF,
    parameter int HITS_PER_LVL = HITS_PER_LVL_DEF,
    parameter int LIVES0       = LIVES0_DEF,
    parameter int SERVE_FRAMES = SERVE_FRAMES_DEF,
    parameter int MISS_FRAMES  = MISS_FRAMES_DEF
) (
    input  logic              CLK_65MHz,
    input  logic              Clear,
    pong_game_ctrl_if.slave   bus
);

    localparam logic [3:0]  VEL0_C    = 4'(BALL_VEL0);
    localparam logic [10:0] VSTEP_C   = 11'(VEL_STEP);
    localparam logic [10:0] VMAX_C    = 11'(VEL_MAX);
    localparam logic [9:0]  BAR0_C    = 10'(BAR_S0);
    localparam logic [10:0] BDEC_C    = 11'(BAR_DEC);
    localparam logic [10:0] BMIN_C    = 11'(BAR_MIN);
    localparam logic [3:0]  HPL_C     = 4'(HITS_PER_LVL);
    localparam logic [1:0]  LIVES0_C  = 2'(LIVES0);

    pong_state_t state_reg, state_next;
    logic [3:0]  ball_vel_reg, ball_vel_next;
    logic [9:0]  bar_size_reg, bar_size_next;
    logic [7:0]  score_reg,    score_next;
    logic [1:0]  lives_reg,    lives_next;
    logic [3:0]  level_reg,    level_next;
    logic [3:0]  hit_cnt_reg,  hit_cnt_next;
    logic        play_en_reg,  ball_rst_reg;

    logic                   timer_done;
    logic                   frame_tick;
    logic [FRAME_CNT_W-1:0] timer_target;
    logic [10:0]            vel_sum;

    assign timer_target = (state_reg == MISS) ? FRAME_CNT_W'(MISS_FRAMES)
                                              : FRAME_CNT_W'(SERVE_FRAMES);

    pong_frame_timer u_timer (
        .CLK_65MHz (CLK_65MHz),
        .Clear     (Clear),
        .HCount    (bus.HCount),
        .VCount    (bus.VCount),
        .clr       (state_next != state_reg),
        .target    (timer_target),
        .frame_tick(frame_tick),
        .done      (timer_done)
    );

    assign vel_sum = 11'(ball_vel_reg) + VSTEP_C;

    always_comb begin
        state_next    = state_reg;
        ball_vel_next = ball_vel_reg;
        bar_size_next = bar_size_reg;
        score_next    = score_reg;
        lives_next    = lives_reg;
        level_next    = level_reg;
        hit_cnt_next  = hit_cnt_reg;

        if (!bus.GameOn) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE, OVER: begin
                    if (bus.GameStartdb) begin
                        state_next    = SERVE;
                        lives_next    = LIVES0_C;
                        score_next    = '0;
                        level_next    = '0;
                        hit_cnt_next  = '0;
                        ball_vel_next = VEL0_C;
                        bar_size_next = BAR0_C;
                    end
                end
                SERVE: if (timer_done) state_next = PLAY;
                MISS:  if (timer_done) state_next = SERVE;
                PLAY: begin
                    // A miss in the same cycle as a hit discards the hit.
                    if (bus.ball_miss) begin
                        lives_next = lives_reg - 2'd1;
                        state_next = (lives_reg == 2'd1) ? OVER : MISS;
                    end else if (bus.paddle_hit) begin
                        if (score_reg != 8'hFF) score_next = score_reg + 8'd1;
                        hit_cnt_next = hit_cnt_reg + 4'd1;
                        if (hit_cnt_reg + 4'd1 == HPL_C) begin
                            hit_cnt_next  = '0;
                            if (level_reg != 4'hF) level_next = level_reg + 4'd1;
                            ball_vel_next = (vel_sum > VMAX_C) ? VMAX_C[3:0] : vel_sum[3:0];
                            bar_size_next = (11'(bar_size_reg) < BMIN_C + BDEC_C)
                                          ? BMIN_C[9:0]
                                          : bar_size_reg - BDEC_C[9:0];
                        end
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK_65MHz) begin
        if (!Clear) begin
            state_reg    <= IDLE;
            ball_vel_reg <= VEL0_C;
            bar_size_reg <= BAR0_C;
            score_reg    <= '0;
            lives_reg    <= LIVES0_C;
            level_reg    <= '0;
            hit_cnt_reg  <= '0;
            play_en_reg  <= 1'b0;
            ball_rst_reg <= 1'b1;
        end else begin
            state_reg    <= state_next;
            ball_vel_reg <= ball_vel_next;
            bar_size_reg <= bar_size_next;
            score_reg    <= score_next;
            lives_reg    <= lives_next;
            level_reg    <= level_next;
            hit_cnt_reg  <= hit_cnt_next;
            play_en_reg  <= (state_next == PLAY);
            ball_rst_reg <= (state_next != PLAY);
        end
    end

    assign bus.frame_tick = frame_tick;
    assign bus.play_en    = play_en_reg;
    assign bus.ball_rst   = ball_rst_reg;
    assign bus.ball_vel   = ball_vel_reg;
    assign bus.bar_size   = bar_size_reg;
    assign bus.score      = score_reg;
    assign bus.lives      = lives_reg;
    assign bus.level      = level_reg;
    assign bus.state      = state_reg;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Directed bench for pong_game_ctrl: serve timing, levelling and clamps,
// miss/over flow, GameOn override and synchronous reset.
module tb_pong_game_ctrl;

    logic clk = 1'b0;
    logic Clear;
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    pong_game_ctrl_if bus ();

    pong_game_ctrl dut (
        .CLK_65MHz(clk),
        .Clear    (Clear),
        .bus      (bus.slave)
    );

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) begin
            n_pass++;
            $display("check %-16s got %0d", tag, obs);
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Raster origin for one cycle; the registered tick is visible one cycle later.
    task automatic frame(input bit chk);
        bus.HCount = 17'd0;
        bus.VCount = 17'd0;
        @(negedge clk);
        bus.HCount = 17'd1;
        bus.VCount = 17'd1;
        if (chk) check("frame_tick_hi", int'(bus.frame_tick), 1);
        @(negedge clk);
        if (chk) check("frame_tick_lo", int'(bus.frame_tick), 0);
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) frame(1'b0);
    endtask

    task automatic pulse(input bit s, input bit h, input bit m);
        bus.GameStartdb = s;
        bus.paddle_hit  = h;
        bus.ball_miss   = m;
        @(negedge clk);
        bus.GameStartdb = 1'b0;
        bus.paddle_hit  = 1'b0;
        bus.ball_miss   = 1'b0;
    endtask

    task automatic check_stats(input string tag, input int sc, input int lv,
                               input int vel, input int bar);
        check({tag, "_score"}, int'(bus.score), sc);
        check({tag, "_level"}, int'(bus.level), lv);
        check({tag, "_vel"},   int'(bus.ball_vel), vel);
        check({tag, "_bar"},   int'(bus.bar_size), bar);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_state"},  int'(bus.state), 0);
        check({tag, "_tick"},   int'(bus.frame_tick), 0);
        check({tag, "_playen"}, int'(bus.play_en), 0);
        check({tag, "_ballrst"},int'(bus.ball_rst), 1);
        check({tag, "_lives"},  int'(bus.lives), 3);
        check_stats(tag, 0, 0, 5, 200);
    endtask

    initial begin
        Clear           = 1'b0;
        bus.GameOn      = 1'b0;
        bus.GameStartdb = 1'b0;
        bus.paddle_hit  = 1'b0;
        bus.ball_miss   = 1'b0;
        bus.HCount      = 17'd1;
        bus.VCount      = 17'd1;
        repeat (3) @(negedge clk);
        check_reset("rst");

        // Serve: 59 ticks keep SERVE, the 60th enters PLAY.
        Clear      = 1'b1;
        bus.GameOn = 1'b1;
        @(negedge clk);
        pulse(1'b1, 1'b0, 1'b0);
        check("serve_state", int'(bus.state), 1);
        check("serve_ballrst", int'(bus.ball_rst), 1);
        check("serve_lives", int'(bus.lives), 3);
        frame(1'b1);
        frames(58);
        check("serve59_state", int'(bus.state), 1);
        check("serve59_playen", int'(bus.play_en), 0);
        frame(1'b0);
        check("play_state", int'(bus.state), 2);
        check("play_playen", int'(bus.play_en), 1);
        check("play_ballrst", int'(bus.ball_rst), 0);
        check_stats("play0", 0, 0, 5, 200);

        // Levelling and clamps.
        repeat (2) pulse(1'b0, 1'b1, 1'b0);
        check_stats("hit2", 2, 1, 7, 150);
        repeat (2) pulse(1'b0, 1'b1, 1'b0);
        check_stats("hit4", 4, 2, 9, 100);
        repeat (6) pulse(1'b0, 1'b1, 1'b0);
        check_stats("hit10", 10, 5, 15, 50);
        repeat (2) pulse(1'b0, 1'b1, 1'b0);
        check_stats("hit12", 12, 6, 15, 50);
        pulse(1'b1, 1'b0, 1'b0);
        check("start_in_play", int'(bus.state), 2);

        // Hit and miss together: miss wins.
        pulse(1'b0, 1'b1, 1'b1);
        check("hm_state", int'(bus.state), 3);
        check("hm_lives", int'(bus.lives), 2);
        check("hm_score", int'(bus.score), 12);
        check("hm_playen", int'(bus.play_en), 0);
        pulse(1'b0, 1'b1, 1'b0);
        check("hit_in_miss", int'(bus.score), 12);
        frames(89);
        check("miss89_state", int'(bus.state), 3);
        frame(1'b0);
        check("miss90_state", int'(bus.state), 1);
        check_stats("retain", 12, 6, 15, 50);

        // Run down to game over.
        frames(60);
        pulse(1'b0, 1'b0, 1'b1);
        check("miss2_lives", int'(bus.lives), 1);
        frames(90);
        frames(60);
        check("p3_state", int'(bus.state), 2);
        pulse(1'b0, 1'b0, 1'b1);
        check("over_state", int'(bus.state), 4);
        check("over_lives", int'(bus.lives), 0);
        check("over_score", int'(bus.score), 12);
        check("over_ballrst", int'(bus.ball_rst), 1);
        pulse(1'b1, 1'b0, 1'b0);
        check("restart_state", int'(bus.state), 1);
        check("restart_lives", int'(bus.lives), 3);
        check_stats("restart", 0, 0, 5, 200);

        // GameOn drop in MISS forces IDLE.
        frames(60);
        pulse(1'b0, 1'b0, 1'b1);
        frames(10);
        check("miss_mid_state", int'(bus.state), 3);
        bus.GameOn = 1'b0;
        @(negedge clk);
        check("gameoff_state", int'(bus.state), 0);
        check("gameoff_ballrst", int'(bus.ball_rst), 1);

        // Clear mid-SERVE, then a fresh serve must take the full 60 ticks.
        bus.GameOn = 1'b1;
        pulse(1'b1, 1'b0, 1'b0);
        frames(20);
        check("serve_mid_state", int'(bus.state), 1);
        Clear = 1'b0;
        @(negedge clk);
        check_reset("clr");
        Clear = 1'b1;
        pulse(1'b1, 1'b0, 1'b0);
        frames(59);
        check("reserve59_state", int'(bus.state), 1);
        frame(1'b0);
        check("reserve60_state", int'(bus.state), 2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pong_game_ctrl.md
PONG_GAME_CTRL -- requirements
Module: pong_game_ctrl

Interface
REQ-001 Parameters (name, default, meaning), one per line:
  BALL_VEL0 5 ball speed after serve;
  VEL_STEP 2 speed increment per level;
  VEL_MAX 15 speed ceiling;
  BAR_S0 200 paddle height after serve;
  BAR_DEC 50 paddle shrink per level;
  BAR_MIN 50 paddle floor;
  HITS_PER_LVL 2 paddle hits per level-up;
  LIVES0 3 lives at game start;
  SERVE_FRAMES 60 serve delay in frames;
  MISS_FRAMES 90 post-miss pause in frames.
REQ-002 Ports (name, direction, width, meaning), one per line:
  CLK_65MHz in 1 pixel clock, sole clock;
  Clear in 1 synchronous, active-low reset;
  GameOn in 1 game-enable switch level;
  GameStartdb in 1 debounced start, one-cycle pulse;
  HCount in 17 current pixel column;
  VCount in 17 current line;
  paddle_hit in 1 one-cycle pulse, ball reflected by paddle;
  ball_miss in 1 one-cycle pulse, ball passed paddle;
  frame_tick out 1 one-cycle pulse per frame;
  play_en out 1 ball/paddle motion enable;
  ball_rst out 1 ball/paddle return to home position;
  ball_vel out 4 current ball speed;
  bar_size out 10 current paddle height;
  score out 8 paddle hits this game;
  lives out 2 remaining lives;
  level out 4 current level;
  state out 3 FSM state code.

Function
REQ-003 frame_tick SHALL be registered, high for exactly the one cycle after HCount==0 && VCount==0 is sampled.
REQ-004 FSM states SHALL be IDLE=0, SERVE=1, PLAY=2, MISS=3, OVER=4.
REQ-005 IDLE->SERVE on GameStartdb while GameOn=1; on entry set lives=LIVES0, score=0, level=0, ball_vel=BALL_VEL0, bar_size=BAR_S0.
REQ-006 SERVE SHALL count frame_ticks and move to PLAY on the SERVE_FRAMES-th tick.
REQ-007 In PLAY, paddle_hit SHALL increment score (saturating at 255) and the hit counter.
REQ-008 When the hit counter reaches HITS_PER_LVL, on the same edge: clear the hit counter; increment level (saturating at 15); set ball_vel=min(ball_vel+VEL_STEP, VEL_MAX); set bar_size=max(bar_size-BAR_DEC, BAR_MIN). Arithmetic SHALL be computed at 11 bits before clamping, with no wrap.
REQ-009 In PLAY, ball_miss SHALL decrement lives and enter MISS; if lives was 1, it SHALL enter OVER instead.
REQ-010 If ball_miss and paddle_hit are asserted in the same cycle, the miss SHALL win and the hit SHALL be ignored.
REQ-011 MISS SHALL count MISS_FRAMES frame_ticks, then enter SERVE. ball_vel, bar_size and level SHALL be retained.
REQ-012 OVER SHALL hold score, level and lives=0 and move to SERVE only on GameStartdb, with the full re-initialisation of REQ-005.
REQ-013 GameOn=0 in any state SHALL force IDLE on the next edge, taking priority over all other events.
REQ-014 GameStartdb SHALL be ignored in SERVE, PLAY and MISS.
REQ-015 Event pulses SHALL be ignored outside PLAY.
REQ-016 play_en SHALL be 1 only in PLAY; ball_rst SHALL be 1 in IDLE, SERVE, MISS and OVER. Both SHALL be registered and decoded from the next state, so they are valid in the first cycle of each state.
REQ-017 The frame counter SHALL clear on every state change; it SHALL count only on frame_tick.

Reset
REQ-018 When Clear=0 at a clock edge: state=IDLE, frame_tick=0, play_en=0, ball_rst=1, ball_vel=BALL_VEL0, bar_size=BAR_S0, score=0, lives=LIVES0, level=0, and the hit and frame counters =0.
REQ-019 Reset SHALL abort any state, including mid-SERVE or MISS countdown, with no residual count.

Structure
REQ-020 State encoding and all default constants SHALL live in shared package pong_pkg, for use by the graphics and this block.
REQ-021 A single sub-module, pong_frame_timer, SHALL contain the frame_tick generator and the frame counter with its done flag. The FSM and stats registers SHALL stay in pong_game_ctrl.

Verification
REQ-022 Reset, then GameOn=1 and a GameStartdb pulse -> state=SERVE; play_en=1 exactly 60 frame_ticks later; lives=3, ball_vel=5, bar_size=200.
REQ-023 In PLAY, 4 paddle_hit pulses -> score=4, level=2, ball_vel=9, bar_size=100.
REQ-024 10 hits -> ball_vel=15 (clamped), bar_size=50 (clamped), level=5.
REQ-025 Simultaneous paddle_hit and ball_miss with lives=3 -> score unchanged, lives=2, state=MISS; after 90 ticks state=SERVE.
REQ-026 Three misses -> state=OVER, lives=0. A GameStartdb pulse -> SERVE with score=0, lives=3.
REQ-027 GameOn=0 mid-MISS -> IDLE next cycle. Clear=0 mid-SERVE -> all REQ-018 values next cycle.
